// File: rtl/ping_scheduler.sv
// rtl/ping_scheduler.sv - acoustic ping burst sequencer for the USBL transmitter
//
// Generates square-wave carrier bursts of n_cycles cycles at half_period
// clocks per half, separated by gap silent clocks, repeated n_pings times
// (0 = continuous until abort).
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start, abort  single-cycle sequence start / immediate stop requests
//   half_period   carrier half-period in clocks (sampled on accepted start)
//   n_cycles      carrier cycles per ping (sampled on accepted start)
//   gap           silent clocks between pings (sampled on accepted start)
//   n_pings       pings per sequence, 0 = continuous
//   sig_out       carrier drive to transducer
//   tx_en         high on every burst clock
//   busy          high while a sequence is active
//   ping_strobe   pulse on the first clock of each burst
//   done          pulse when a finite sequence completes
//   aborted       pulse when abort terminates an active sequence
//   cfg_err       pulse when start is rejected for a zero field
//   ping_count    pings started in the current or last sequence
module ping_scheduler #(
  parameter int DIV_W = 16,
  parameter int CYC_W = 16,
  parameter int GAP_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CYC_W-1:0] n_cycles,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] n_pings,
  output logic             sig_out,
  output logic             tx_en,
  output logic             busy,
  output logic             ping_strobe,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] ping_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] cfg_h;
  logic [CYC_W-1:0] cfg_n;
  logic [GAP_W-1:0] cfg_g;
  logic [CNT_W-1:0] cfg_p;
  // Down-counters hold the clocks/cycles remaining after the current one.
  logic [DIV_W-1:0] half_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic start_ok;
  logic more_pings;

  assign start_ok   = start && !abort && (half_period != '0) && (n_cycles != '0);
  assign more_pings = (cfg_p == '0) || (ping_count < cfg_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_h       <= '0;
      cfg_n       <= '0;
      cfg_g       <= '0;
      cfg_p       <= '0;
      half_cnt    <= '0;
      cyc_cnt     <= '0;
      gap_cnt     <= '0;
      sig_out     <= 1'b0;
      tx_en       <= 1'b0;
      busy        <= 1'b0;
      ping_strobe <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      ping_count  <= '0;
    end else begin
      ping_strobe <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cfg_h       <= half_period;
            cfg_n       <= n_cycles;
            cfg_g       <= gap;
            cfg_p       <= n_pings;
            // Count is cleared and the first ping is counted in one step.
            ping_count  <= CNT_W'(1);
            state       <= S_BURST;
            sig_out     <= 1'b1;
            tx_en       <= 1'b1;
            busy        <= 1'b1;
            ping_strobe <= 1'b1;
            half_cnt    <= half_period - DIV_W'(1);
            cyc_cnt     <= n_cycles - CYC_W'(1);
          end else if (start && !abort) begin
            cfg_err <= 1'b1;
          end
        end

        S_BURST: begin
          if (abort) begin
            state   <= S_IDLE;
            sig_out <= 1'b0;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (half_cnt != '0) begin
            half_cnt <= half_cnt - DIV_W'(1);
          end else if (sig_out) begin
            sig_out  <= 1'b0;
            half_cnt <= cfg_h - DIV_W'(1);
          end else if (cyc_cnt != '0) begin
            cyc_cnt  <= cyc_cnt - CYC_W'(1);
            sig_out  <= 1'b1;
            half_cnt <= cfg_h - DIV_W'(1);
          end else if (!more_pings) begin
            // Final ping ends without a trailing gap.
            state <= S_IDLE;
            tx_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cfg_g == '0) begin
            sig_out     <= 1'b1;
            ping_strobe <= 1'b1;
            ping_count  <= ping_count + CNT_W'(1);
            half_cnt    <= cfg_h - DIV_W'(1);
            cyc_cnt     <= cfg_n - CYC_W'(1);
          end else begin
            state   <= S_GAP;
            tx_en   <= 1'b0;
            gap_cnt <= cfg_g - GAP_W'(1);
          end
        end

        S_GAP: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else begin
            state       <= S_BURST;
            sig_out     <= 1'b1;
            tx_en       <= 1'b1;
            ping_strobe <= 1'b1;
            ping_count  <= ping_count + CNT_W'(1);
            half_cnt    <= cfg_h - DIV_W'(1);
            cyc_cnt     <= cfg_n - CYC_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          sig_out <= 1'b0;
          tx_en   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ping_scheduler.sv
// tb/tb_ping_scheduler.sv - self-checking bench for ping_scheduler
module tb_ping_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] half_period;
  logic [15:0] n_cycles;
  logic [31:0] gap;
  logic [7:0]  n_pings;
  logic        sig_out, tx_en, busy, ping_strobe, done, aborted, cfg_err;
  logic [7:0]  ping_count;

  int n_pass  = 0;
  int n_total = 0;

  ping_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .half_period(half_period), .n_cycles(n_cycles), .gap(gap), .n_pings(n_pings),
    .sig_out(sig_out), .tx_en(tx_en), .busy(busy), .ping_strobe(ping_strobe),
    .done(done), .aborted(aborted), .cfg_err(cfg_err), .ping_count(ping_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: clock k (k=1 is the first clock after the accepted start) of
  // a sequence. Ping period is 2NH+G; the last ping has no trailing gap.
  task automatic model(input int k, input int h, input int n, input int g, input int p,
                       output bit s, output bit tx, output bit b, output bit st,
                       output bit d, output int pc);
    int per, bl, t, idx, pos, total;
    bl  = 2 * n * h;
    per = bl + g;
    t   = k - 1;
    idx = t / per;
    pos = t % per;
    total = p * per - g;
    s = 0; tx = 0; b = 0; st = 0; d = 0;
    if (p != 0 && t >= total) begin
      d  = (t == total);
      pc = p % 256;
    end else begin
      b  = 1;
      pc = (idx + 1) % 256;
      if (pos < bl) begin
        tx = 1;
        s  = ((pos / h) % 2) == 0;
        st = (pos == 0);
      end
    end
  endtask

  // Starts a sequence and checks every output for ncyc clocks. abort_at>0
  // pulses abort during clock abort_at. noise drives ignored starts and
  // scrambles the config inputs after acceptance.
  task automatic run_seq(input string name, input int h, input int n, input int g, input int p,
                         input int ncyc, input int abort_at, input bit noise);
    bit s, tx, b, st, d, ab;
    int pc, held_pc, total;
    total = p * (2 * n * h + g) - g;
    held_pc = 0;
    half_period = 16'(h); n_cycles = 16'(n); gap = 32'(g); n_pings = 8'(p);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      model(k, h, n, g, p, s, tx, b, st, d, pc);
      ab = 0;
      if (abort_at > 0 && k == abort_at) held_pc = pc;
      if (abort_at > 0 && k > abort_at) begin
        s = 0; tx = 0; b = 0; st = 0; d = 0;
        ab = (k == abort_at + 1);
        pc = held_pc;
      end
      chk($sformatf("%s sig_out k=%0d", name, k), sig_out, s);
      chk($sformatf("%s tx_en k=%0d", name, k), tx_en, tx);
      chk($sformatf("%s busy k=%0d", name, k), busy, b);
      chk($sformatf("%s ping_strobe k=%0d", name, k), ping_strobe, st);
      chk($sformatf("%s done k=%0d", name, k), done, d);
      chk($sformatf("%s aborted k=%0d", name, k), aborted, ab);
      chk($sformatf("%s cfg_err k=%0d", name, k), cfg_err, 0);
      chk($sformatf("%s ping_count k=%0d", name, k), ping_count, pc);
      abort = (abort_at > 0 && k == abort_at);
      start = 1'b0;
      if (noise && (abort_at == 0 || k < abort_at) && (p == 0 || k <= total)) begin
        start = ($urandom_range(0, 3) == 0);
        half_period = 16'($urandom_range(0, 9));
        n_cycles = 16'($urandom_range(0, 9));
        gap = 32'($urandom_range(0, 9));
        n_pings = 8'($urandom_range(0, 9));
      end
      cyc();
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int h, n, g, p, per, ab_at;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; n_cycles = '0; gap = '0; n_pings = '0;
    cyc(); cyc();
    chk("reset sig_out", sig_out, 0);
    chk("reset busy", busy, 0);
    chk("reset ping_count", ping_count, 0);
    rst = 1'b0;
    cyc();

    // Asynchronous reset in the middle of a burst.
    run_seq("pre_reset", 5, 10, 3, 1, 7, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst sig_out", sig_out, 0);
    chk("async rst tx_en", tx_en, 0);
    chk("async rst busy", busy, 0);
    chk("async rst ping_count", ping_count, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post reset busy", busy, 0);

    run_seq("nominal", 2, 3, 4, 2, 31, 0, 0);
    run_seq("zero_gap", 1, 2, 0, 3, 15, 0, 0);
    run_seq("abort", 4, 8, 10, 0, 26, 20, 0);

    // Rejected starts and start+abort in idle.
    half_period = 16'd0; n_cycles = 16'd3; start = 1'b1;
    cyc(); start = 1'b0;
    chk("cfg_err h0 pulse", cfg_err, 1);
    chk("cfg_err h0 busy", busy, 0);
    cyc();
    chk("cfg_err h0 clears", cfg_err, 0);
    half_period = 16'd3; n_cycles = 16'd0; start = 1'b1;
    cyc(); start = 1'b0;
    chk("cfg_err n0 pulse", cfg_err, 1);
    chk("cfg_err n0 busy", busy, 0);
    n_cycles = 16'd3; start = 1'b1; abort = 1'b1;
    cyc(); start = 1'b0; abort = 1'b0;
    chk("start+abort cfg_err", cfg_err, 0);
    chk("start+abort busy", busy, 0);
    chk("start+abort strobe", ping_strobe, 0);
    chk("start+abort aborted", aborted, 0);
    cyc();

    // Continuous wrap: the 256th strobe lands at k=511 with ping_count 0.
    run_seq("wrap", 1, 1, 0, 0, 516, 513, 1);

    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(1, 4); n = $urandom_range(1, 4);
      g = $urandom_range(0, 6); p = $urandom_range(1, 4);
      per = 2 * n * h + g;
      run_seq($sformatf("rand%0d", i), h, n, g, p, p * per - g + 3, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      h = $urandom_range(1, 4); n = $urandom_range(1, 4);
      g = $urandom_range(0, 6);
      ab_at = $urandom_range(2, 60);
      run_seq($sformatf("rabort%0d", i), h, n, g, 0, ab_at + 4, ab_at, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
